row_normalizer: RTL and testbench



---
 rtl/row_normalizer_pkg.sv | 10 +
 rtl/row_normalizer_if.sv | 31 +++
 rtl/row_normalizer.sv | 91 +++++++++
 tb/tb_row_normalizer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/row_normalizer_pkg.sv
// Shared types and constants for the row normalization sequencer.
package row_normalizer_pkg;
  localparam int ROW_LEN   = 64;
  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] DIV_INPUT_QT;
  typedef logic signed [31:0] OUTPUT_VEC_QT;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} NORM_STATE_T;
endpackage

// File: rtl/row_normalizer_if.sv
// Upstream row, divider pair/quotient and downstream row handshakes.
interface row_normalizer_if
  import row_normalizer_pkg::*;
#(
  parameter int VEC_LEN = ROW_LEN
);
  logic                              vld_in;
  logic                              rdy_out;
  DIV_INPUT_QT  [VEC_LEN-1:0]        row_in;
  DIV_INPUT_QT                       denom_in;
  logic                              div_vld_out;
  logic                              div_rdy_in;
  DIV_INPUT_QT                       div_num_out;
  DIV_INPUT_QT                       div_den_out;
  logic                              div_vld_in;
  logic                              div_rdy_out;
  OUTPUT_VEC_QT                      div_quot_in;
  logic                              vld_out;
  logic                              rdy_in;
  OUTPUT_VEC_QT [VEC_LEN-1:0]        row_out;

  modport slave (
    input  vld_in, row_in, denom_in, div_rdy_in, div_vld_in, div_quot_in, rdy_in,
    output rdy_out, div_vld_out, div_num_out, div_den_out, div_rdy_out, vld_out, row_out
  );

  modport master (
    output vld_in, row_in, denom_in, div_rdy_in, div_vld_in, div_quot_in, rdy_in,
    input  rdy_out, div_vld_out, div_num_out, div_den_out, div_rdy_out, vld_out, row_out
  );
endinterface

// File: rtl/row_normalizer.sv
// Streams num/den pairs of one row to an external divider, one at a time,
// and gathers the quotients in order into the normalized output row.
module row_normalizer
  import row_normalizer_pkg::*;
#(
  parameter int VEC_LEN = ROW_LEN,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input logic             clk,
  input logic             rst,
  row_normalizer_if.slave bus
);

  NORM_STATE_T                state, state_nxt;
  logic [IDX_W-1:0]           idx, idx_nxt;
  DIV_INPUT_QT  [VEC_LEN-1:0] num_buf;
  DIV_INPUT_QT                den_reg;
  OUTPUT_VEC_QT [VEC_LEN-1:0] out_buf;
  logic                       accept, wr_en, last, bypass;
  OUTPUT_VEC_QT               wr_data;

  assign last   = (idx == IDX_W'(VEC_LEN - 1));
  assign bypass = (den_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      num_buf <= '0;
      den_reg <= '0;
      out_buf <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        num_buf <= bus.row_in;
        den_reg <= bus.denom_in;
      end
      if (wr_en) out_buf[idx] <= wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state)
      IDLE: if (bus.vld_in) begin
        accept    = 1'b1;
        idx_nxt   = '0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        // A zero denominator skips the divider and stores 0 for the element.
        if (bypass) begin
          wr_en = 1'b1;
          if (last) state_nxt = OUT;
          else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = ISSUE;
          end
        end else if (bus.div_rdy_in) begin
          state_nxt = WAIT;
        end
      end
      WAIT: if (bus.div_vld_in) begin
        wr_en   = 1'b1;
        wr_data = bus.div_quot_in;
        if (last) state_nxt = OUT;
        else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = ISSUE;
        end
      end
      OUT: if (bus.rdy_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is only raised from ISSUE, so at most one pair is ever in flight.
  assign bus.rdy_out     = (state == IDLE);
  assign bus.div_vld_out = (state == ISSUE) && !bypass;
  assign bus.div_num_out = num_buf[idx];
  assign bus.div_den_out = den_reg;
  assign bus.div_rdy_out = (state == WAIT);
  assign bus.vld_out     = (state == OUT);
  assign bus.row_out     = out_buf;

endmodule

// File: tb/tb_row_normalizer.sv
// Normalizer plus a behavioural fixed-latency divider, checked against per-row expectations.
module tb_row_normalizer;
  import row_normalizer_pkg::*;

  localparam int VLEN  = 4;
  localparam int L_DIV = 3;
  localparam int ONE   = 1 << FRAC_BITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_normalizer_if #(.VEC_LEN(VLEN)) bus();
  row_normalizer #(.VEC_LEN(VLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  function automatic OUTPUT_VEC_QT fx_div(input DIV_INPUT_QT n, input DIV_INPUT_QT d);
    longint t;
    if (d == 0) return '0;
    t = longint'(n) * longint'(ONE);
    return OUTPUT_VEC_QT'(t / longint'(d));
  endfunction

  // Divider stub: accepts only when idle, answers L_DIV cycles later, can stall.
  int          stall_len = 0;
  logic        stray     = 1'b0;
  logic        busy;
  int          lcnt, wait_cnt;
  DIV_INPUT_QT q_num, q_den;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0; lcnt <= 0; wait_cnt <= 0; q_num <= '0; q_den <= '0;
    end else if (bus.div_vld_out && bus.div_rdy_in) begin
      busy <= 1'b1; lcnt <= L_DIV; wait_cnt <= 0;
      q_num <= bus.div_num_out; q_den <= bus.div_den_out;
    end else begin
      if (bus.div_vld_out) wait_cnt <= wait_cnt + 1;
      if (busy) begin
        if (lcnt != 0) lcnt <= lcnt - 1;
        else if (bus.div_rdy_out) busy <= 1'b0;
      end
    end
  end

  assign bus.div_rdy_in  = !busy && (wait_cnt >= stall_len);
  assign bus.div_vld_in  = (busy && lcnt == 0) || stray;
  assign bus.div_quot_in = stray ? OUTPUT_VEC_QT'(32'h0bad_beef) : fx_div(q_num, q_den);

  // Protocol monitors
  int          hs_cnt = 0, dvo_cnt = 0, dbl_cnt = 0, unstable_cnt = 0;
  logic        last_stalled = 1'b0;
  DIV_INPUT_QT last_num;
  always @(posedge clk) begin
    if (bus.div_vld_out && bus.div_rdy_in) hs_cnt <= hs_cnt + 1;
    if (bus.div_vld_out) dvo_cnt <= dvo_cnt + 1;
    if (bus.div_vld_out && busy) dbl_cnt <= dbl_cnt + 1;
    if (last_stalled && (!bus.div_vld_out || bus.div_num_out != last_num))
      unstable_cnt <= unstable_cnt + 1;
    last_stalled <= bus.div_vld_out && !bus.div_rdy_in;
    last_num     <= bus.div_num_out;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input DIV_INPUT_QT r[VLEN], input DIV_INPUT_QT d, input bit keep);
    int n = 0;
    bus.vld_in   = 1'b1;
    bus.denom_in = d;
    for (int i = 0; i < VLEN; i++) bus.row_in[i] = r[i];
    while (!bus.rdy_out && n < 500) begin tick(); n++; end
    chk("accept_timeout", longint'(n < 500), 1);
    tick();
    if (!keep) bus.vld_in = 1'b0;
  endtask

  // Waits for the row, checks contents/latency, holds rdy_in low for 'hold' cycles.
  task automatic collect(input string tag, input OUTPUT_VEC_QT e[VLEN],
                         input int exp_lat, input int hold);
    int lat = 1;
    int bad = 0;
    OUTPUT_VEC_QT [VLEN-1:0] snap;
    OUTPUT_VEC_QT g;
    while (!bus.vld_out && lat < 2000) begin tick(); lat++; end
    chk({tag, "_vld"}, longint'(bus.vld_out), 1);
    if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
    for (int i = 0; i < VLEN; i++) begin
      g = bus.row_out[i];
      chk($sformatf("%s_e%0d", tag, i), longint'(g), longint'(e[i]));
    end
    snap = bus.row_out;
    for (int c = 0; c < hold; c++) begin
      stray = (c == 1);
      tick();
      if (!bus.vld_out || bus.row_out != snap || bus.rdy_out) bad++;
    end
    stray = 1'b0;
    if (hold > 0) chk({tag, "_hold"}, bad, 0);
    bus.rdy_in = 1'b1;
    tick();
    bus.rdy_in = 1'b0;
    chk({tag, "_vld_one"}, longint'(bus.vld_out), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy_out"}, longint'(bus.rdy_out), 1);
    chk({tag, "_vld_out"}, longint'(bus.vld_out), 0);
    chk({tag, "_div_vld"}, longint'(bus.div_vld_out), 0);
    chk({tag, "_div_rdy"}, longint'(bus.div_rdy_out), 0);
    chk({tag, "_row_out"}, longint'(bus.row_out != '0), 0);
    chk({tag, "_num_den"}, longint'(bus.div_num_out != '0 || bus.div_den_out != '0), 0);
  endtask

  DIV_INPUT_QT  ra[VLEN], rb[VLEN];
  OUTPUT_VEC_QT ea[VLEN], eb[VLEN];
  DIV_INPUT_QT  da, db;
  int           base, n;

  initial begin
    rst = 1'b0;
    bus.vld_in = 1'b0; bus.rdy_in = 1'b0; bus.row_in = '0; bus.denom_in = '0;
    tick(); tick();
    chk_reset_outputs("por");
    rst = 1'b1;
    stray = 1'b1; tick(); stray = 1'b0; tick();
    chk("idle_stray", longint'(bus.rdy_out), 1);

    // Basic row, 2.0 denominator
    ra = '{ONE, -2*ONE, 3*ONE, ONE/2};
    ea = '{ONE/2, -ONE, 3*ONE/2, ONE/4};
    base = hs_cnt;
    send(ra, 2*ONE, 1'b0);
    collect("basic", ea, VLEN*(L_DIV+2)+1, 0);
    chk("basic_hs", hs_cnt - base, VLEN);

    // Zero denominator bypasses the divider
    ra = '{ONE, ONE, ONE, ONE};
    ea = '{0, 0, 0, 0};
    base = dvo_cnt;
    send(ra, 0, 1'b0);
    collect("zero", ea, VLEN+1, 0);
    chk("zero_no_div", dvo_cnt - base, 0);

    // Divider stalls 5 cycles per element
    stall_len = 5;
    ra = '{4*ONE, 8*ONE, -4*ONE, 2*ONE};
    ea = '{-ONE, -2*ONE, ONE, -ONE/2};
    send(ra, -4*ONE, 1'b0);
    collect("stall", ea, VLEN*(L_DIV+2+5)+1, 0);
    stall_len = 0;

    // Downstream backpressure with a second row already waiting, then back-to-back
    ra = '{3*ONE, -6*ONE, 9*ONE, 12*ONE}; da = 3*ONE;
    ea = '{ONE, -2*ONE, 3*ONE, 4*ONE};
    rb = '{5*ONE, 10*ONE, -ONE, 0};       db = ONE/2;
    eb = '{10*ONE, 20*ONE, -2*ONE, 0};
    send(ra, da, 1'b1);
    bus.denom_in = db;
    for (int i = 0; i < VLEN; i++) bus.row_in[i] = rb[i];
    collect("bp", ea, VLEN*(L_DIV+2)+1, 10);
    chk("b2b_rdy_after_hs", longint'(bus.rdy_out), 1);
    tick();
    bus.vld_in = 1'b0;
    chk("b2b_accepted", longint'(bus.rdy_out), 0);
    collect("b2b", eb, VLEN*(L_DIV+2)+1, 0);

    // Reset while waiting on element 2
    ra = '{7*ONE, 7*ONE, 7*ONE, 7*ONE};
    base = hs_cnt;
    send(ra, 7*ONE, 1'b0);
    n = 0;
    while (!((hs_cnt - base) == 3 && bus.div_rdy_out) && n < 200) begin tick(); n++; end
    chk("rst_reach_wait2", longint'(n < 200), 1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_idle", longint'(bus.rdy_out), 1);
    ra = '{2*ONE, 2*ONE, 2*ONE, 2*ONE};
    ea = '{ONE, ONE, ONE, ONE};
    send(ra, 2*ONE, 1'b0);
    collect("post_rst", ea, VLEN*(L_DIV+2)+1, 0);

    // Randomized rows against the reference model
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < VLEN; i++) ra[i] = DIV_INPUT_QT'($signed($urandom_range(0, 1 << 22)) - (1 << 21));
      if ($urandom_range(0, 4) == 0) da = '0;
      else da = DIV_INPUT_QT'($urandom);
      if (da == 0 && $urandom_range(0, 1) == 1) da = ONE;
      for (int i = 0; i < VLEN; i++) ea[i] = (da == 0) ? OUTPUT_VEC_QT'(0) : fx_div(ra[i], da);
      stall_len = $urandom_range(0, 3);
      send(ra, da, 1'b0);
      collect($sformatf("rnd%0d", r), ea,
              (da == 0) ? VLEN+1 : VLEN*(L_DIV+2+stall_len)+1, $urandom_range(0, 3));
    end

    chk("single_outstanding", dbl_cnt, 0);
    chk("stall_stable", unstable_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
